// File: rtl/round_controller.sv
// Memory-game round sequencer: plays a 4-step pattern from ROM, then scores player entries.
// Outputs pass/fail/input_en/led_out are decoded from state and live inputs, so pass/fail land on the entry cycle.
module round_controller #(
  parameter int SEQ_LEN        = 4,
  parameter int STEP_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter int NUM_ROUNDS     = 9
) (
  input  logic        clk50,
  input  logic        KEY2,
  input  logic        start,
  output logic [3:0]  pat_addr,
  input  logic [15:0] pat_data,
  input  logic        btn_valid,
  input  logic [3:0]  btn_code,
  output logic [3:0]  led_out,
  output logic        input_en,
  output logic [3:0]  round,
  output logic [3:0]  score,
  output logic        pass,
  output logic        fail,
  output logic        done
);
  // state    | meaning
  // IDLE     | waiting for start; entries ignored
  // LOAD     | latch pattern for current round
  // SHOW_ON  | step nibble lit for STEP_CYCLES
  // SHOW_OFF | dark gap for GAP_CYCLES
  // WAIT_IN  | entry window, timeout armed
  // FINISH   | all rounds passed, held until reset
  localparam int MAX_SG  = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] STEP_LD = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LD   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    LAST    = 2'(SEQ_LEN - 1);
  localparam logic [3:0]    RND_END = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_FINISH
  } state_t;

  state_t         r_state,  w_state_nx;
  logic [TW-1:0]  r_timer,  w_timer_nx;
  logic [1:0]     r_step,   w_step_nx;
  logic [1:0]     r_idx,    w_idx_nx;
  logic [15:0]    r_shadow, w_shadow_nx;
  logic [3:0]     r_round,  w_round_nx;
  logic [3:0]     r_score,  w_score_nx;
  logic [3:0]     r_last,   w_last_nx;
  logic [3:0]     w_led;
  logic           w_input_en, w_pass, w_fail, w_done;
  logic [3:0]     w_nib_step, w_nib_idx, w_round_inc;
  logic           w_onehot, w_match;

  // Step 0 is the most significant nibble.
  function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] s);
    case (s)
      2'd0: nib = v[15:12];
      2'd1: nib = v[11:8];
      2'd2: nib = v[7:4];
      2'd3: nib = v[3:0];
    endcase
  endfunction

  assign w_nib_step  = nib(r_shadow, r_step);
  assign w_nib_idx   = nib(r_shadow, r_idx);
  assign w_onehot    = (btn_code != 4'd0) && ((btn_code & (btn_code - 4'd1)) == 4'd0);
  assign w_match     = w_onehot && (btn_code == w_nib_idx);
  assign w_round_inc = r_round + 4'd1;

  always_comb begin
    w_state_nx  = r_state;
    w_timer_nx  = r_timer;
    w_step_nx   = r_step;
    w_idx_nx    = r_idx;
    w_shadow_nx = r_shadow;
    w_round_nx  = r_round;
    w_score_nx  = r_score;
    w_last_nx   = r_last;
    w_led       = 4'd0;
    w_input_en  = 1'b0;
    w_pass      = 1'b0;
    w_fail      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nx = S_LOAD;
      S_LOAD: begin
        w_shadow_nx = pat_data;
        w_step_nx   = 2'd0;
        w_timer_nx  = STEP_LD;
        w_state_nx  = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        w_led = w_nib_step;
        if (r_timer == '0) begin
          w_timer_nx = GAP_LD;
          w_state_nx = S_SHOW_OFF;
        end else w_timer_nx = r_timer - 1'b1;
      end
      S_SHOW_OFF: begin
        if (r_timer != '0) w_timer_nx = r_timer - 1'b1;
        else if (r_step == LAST) begin
          w_idx_nx   = 2'd0;
          w_last_nx  = 4'd0;
          w_timer_nx = TO_LD;
          w_state_nx = S_WAIT_IN;
        end else begin
          w_step_nx  = r_step + 2'd1;
          w_timer_nx = STEP_LD;
          w_state_nx = S_SHOW_ON;
        end
      end
      S_WAIT_IN: begin
        w_input_en = 1'b1;
        w_led      = r_last;
        // An entry on the expiry cycle wins over the timeout.
        if (btn_valid) begin
          if (!w_match) begin
            w_fail     = 1'b1;
            w_state_nx = S_IDLE;
          end else if (r_idx == LAST) begin
            w_pass     = 1'b1;
            w_last_nx  = btn_code;
            w_round_nx = w_round_inc;
            w_score_nx = (r_score == 4'hF) ? r_score : r_score + 4'd1;
            w_state_nx = (w_round_inc == RND_END) ? S_FINISH : S_LOAD;
          end else begin
            w_last_nx  = btn_code;
            w_idx_nx   = r_idx + 2'd1;
            w_timer_nx = TO_LD;
          end
        end else if (r_timer == '0) begin
          w_fail     = 1'b1;
          w_state_nx = S_IDLE;
        end else w_timer_nx = r_timer - 1'b1;
      end
      S_FINISH: begin
        w_done = 1'b1;
        w_led  = 4'hF;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (!KEY2) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_step   <= 2'd0;
      r_idx    <= 2'd0;
      r_shadow <= 16'd0;
      r_round  <= 4'd0;
      r_score  <= 4'd0;
      r_last   <= 4'd0;
    end else begin
      r_state  <= w_state_nx;
      r_timer  <= w_timer_nx;
      r_step   <= w_step_nx;
      r_idx    <= w_idx_nx;
      r_shadow <= w_shadow_nx;
      r_round  <= w_round_nx;
      r_score  <= w_score_nx;
      r_last   <= w_last_nx;
    end
  end

  assign pat_addr = r_round;
  assign round    = r_round;
  assign score    = r_score;
  assign led_out  = w_led;
  assign input_en = w_input_en;
  assign pass     = w_pass;
  assign fail     = w_fail;
  assign done     = w_done;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with short timing parameters and a two-round pattern ROM.
module tb_round_controller;
  logic        clk50 = 1'b0;
  logic        KEY2 = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  pat_addr;
  logic [15:0] pat_data;
  logic        btn_valid = 1'b0;
  logic [3:0]  btn_code = 4'd0;
  logic [3:0]  led_out;
  logic        input_en;
  logic [3:0]  round;
  logic [3:0]  score;
  logic        pass;
  logic        fail;
  logic        done;

  int n_vec = 0;
  int n_miss = 0;

  localparam logic [15:0] PAT0 = 16'h2184;
  localparam logic [15:0] PAT1 = 16'h4812;

  round_controller #(
    .SEQ_LEN(4), .STEP_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(20), .NUM_ROUNDS(2)
  ) dut (
    .clk50(clk50), .KEY2(KEY2), .start(start), .pat_addr(pat_addr), .pat_data(pat_data),
    .btn_valid(btn_valid), .btn_code(btn_code), .led_out(led_out), .input_en(input_en),
    .round(round), .score(score), .pass(pass), .fail(fail), .done(done)
  );

  always #5 clk50 = ~clk50;

  assign pat_data = (pat_addr == 4'd0) ? PAT0 : (pat_addr == 4'd1) ? PAT1 : 16'h0000;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle and drive that cycle's inputs, then let outputs settle.
  task automatic cyc(input logic rb, input logic s, input logic bv, input logic [3:0] bc);
    @(posedge clk50);
    #1;
    KEY2 = rb; start = s; btn_valid = bv; btn_code = bc;
    #1;
  endtask

  // Called in the cycle that leads into LOAD; walks cycles 1..25 of playback.
  task automatic play(input logic [15:0] pat, input string tag);
    logic [3:0] e;
    int k, r;
    for (int c = 1; c <= 25; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      e = 4'd0;
      if (c >= 2) begin
        k = (c - 2) / 6;
        r = (c - 2) % 6;
        if (r < 4) e = 4'(pat >> (12 - 4 * k));
      end
      chk($sformatf("%s led c%0d", tag, c), {4'd0, led_out}, {4'd0, e});
      chk($sformatf("%s en c%0d", tag, c), {7'd0, input_en}, 8'd0);
    end
  endtask

  task automatic ent(input logic [3:0] code, input logic [3:0] exp_led,
                     input logic exp_pass, input logic exp_fail, input string tag);
    cyc(1'b1, 1'b0, 1'b1, code);
    chk({tag, " en"}, {7'd0, input_en}, 8'd1);
    chk({tag, " led"}, {4'd0, led_out}, {4'd0, exp_led});
    chk({tag, " pass"}, {7'd0, pass}, {7'd0, exp_pass});
    chk({tag, " fail"}, {7'd0, fail}, {7'd0, exp_fail});
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("rst led", {4'd0, led_out}, 8'd0);
    chk("rst en", {7'd0, input_en}, 8'd0);
    chk("rst round", {4'd0, round}, 8'd0);
    chk("rst score", {4'd0, score}, 8'd0);
    chk("rst addr", {4'd0, pat_addr}, 8'd0);
    chk("rst pf", {6'd0, pass, fail}, 8'd0);
    chk("rst done", {7'd0, done}, 8'd0);

    // Round 0: playback then a correct sequence.
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    play(PAT0, "r0");
    ent(4'h2, 4'h0, 1'b0, 1'b0, "r0 e0");
    ent(4'h1, 4'h2, 1'b0, 1'b0, "r0 e1");
    ent(4'h8, 4'h1, 1'b0, 1'b0, "r0 e2");
    ent(4'h4, 4'h8, 1'b1, 1'b0, "r0 e3");
    play(PAT1, "r1");
    chk("r1 round", {4'd0, round}, 8'd1);
    chk("r1 score", {4'd0, score}, 8'd1);
    chk("r1 addr", {4'd0, pat_addr}, 8'd1);

    // Round 1: mismatch on second entry (non-one-hot code).
    ent(4'h4, 4'h0, 1'b0, 1'b0, "mm e0");
    ent(4'hC, 4'h4, 1'b0, 1'b1, "mm e1");
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("mm idle en", {7'd0, input_en}, 8'd0);
    chk("mm idle led", {4'd0, led_out}, 8'd0);
    chk("mm round", {4'd0, round}, 8'd1);
    chk("mm score", {4'd0, score}, 8'd1);
    chk("mm fail clr", {7'd0, fail}, 8'd0);

    // Entries in IDLE are ignored.
    cyc(1'b1, 1'b0, 1'b1, 4'h8);
    chk("idle btn pf", {6'd0, pass, fail}, 8'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("idle stays", {7'd0, input_en}, 8'd0);

    // Retry, then let the window expire.
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    play(PAT1, "to");
    for (int i = 0; i < 19; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      chk($sformatf("to wait %0d fail", i), {7'd0, fail}, 8'd0);
      chk($sformatf("to wait %0d en", i), {7'd0, input_en}, 8'd1);
    end
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("to expire fail", {7'd0, fail}, 8'd1);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("to idle en", {7'd0, input_en}, 8'd0);
    chk("to round", {4'd0, round}, 8'd1);

    // Retry; the entry on the expiry cycle must win.
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    play(PAT1, "late");
    ent(4'h4, 4'h0, 1'b0, 1'b0, "late e0");
    for (int i = 0; i < 19; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      chk($sformatf("late wait %0d fail", i), {7'd0, fail}, 8'd0);
      chk($sformatf("late wait %0d led", i), {4'd0, led_out}, 8'h4);
    end
    ent(4'h8, 4'h4, 1'b0, 1'b0, "late e1");
    ent(4'h1, 4'h8, 1'b0, 1'b0, "late e2");
    ent(4'h2, 4'h1, 1'b1, 1'b0, "late e3");
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("fin done", {7'd0, done}, 8'd1);
    chk("fin score", {4'd0, score}, 8'd2);
    chk("fin round", {4'd0, round}, 8'd2);
    chk("fin led", {4'd0, led_out}, 8'hF);
    chk("fin en", {7'd0, input_en}, 8'd0);

    // FINISH ignores start and entries.
    cyc(1'b1, 1'b1, 1'b1, 4'h2);
    chk("fin ign pf", {6'd0, pass, fail}, 8'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("fin ign done", {7'd0, done}, 8'd1);
    chk("fin ign round", {4'd0, round}, 8'd2);

    // Reset out of FINISH.
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("rf done", {7'd0, done}, 8'd0);
    chk("rf round", {4'd0, round}, 8'd0);
    chk("rf score", {4'd0, score}, 8'd0);
    chk("rf led", {4'd0, led_out}, 8'd0);

    // Reset mid-SHOW_ON, asserted together with start.
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("ms led c3", {4'd0, led_out}, 8'h2);
    cyc(1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("ms led", {4'd0, led_out}, 8'd0);
    chk("ms en", {7'd0, input_en}, 8'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("ms still idle", {4'd0, led_out}, 8'd0);

    // Reset mid-WAIT_IN, asserted together with an entry.
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    play(PAT0, "mw");
    ent(4'h2, 4'h0, 1'b0, 1'b0, "mw e0");
    cyc(1'b0, 1'b0, 1'b1, 4'h1);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    chk("mw en", {7'd0, input_en}, 8'd0);
    chk("mw led", {4'd0, led_out}, 8'd0);
    chk("mw pf", {6'd0, pass, fail}, 8'd0);
    chk("mw score", {4'd0, score}, 8'd0);

    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    play(PAT0, "rs");
    chk("rs addr", {4'd0, pat_addr}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
